// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
// Latency: none (constants only).
// Backpressure: not applicable.
package if_fetch_unit_pkg;

    // Fetch FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // Instruction presented to IF/ID when nothing valid is held
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Byte address of the first fetch after reset
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem reads, presents one instruction to IF/ID.
// Latency: Gnt cycle -> Rvalid next cycle -> IF_Valid the cycle after (1 instr / 3 cycles at zero wait).
// Backpressure: IF_ID_WR=0 holds the presented instruction bit-stable and blocks the next request.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   IF_ID_WR, ID_IFFlush      IF/ID write enable (consume) and active-low flush (kill presented instr)
//   ID_Redirect, ID_Target    branch/jump redirect to a word address
//   Imem_Req/Addr/Gnt         request phase of the instruction memory handshake
//   Imem_Rvalid/Rdata         response phase of the instruction memory handshake
//   IF_IrOut/PcAddOne/Valid   instruction, its PC+1 word address, and validity toward IF/ID
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IF_ID_WR,
    input  logic        ID_IFFlush,
    input  logic        ID_Redirect,
    input  logic [31:2] ID_Target,
    output logic        Imem_Req,
    output logic [31:2] Imem_Addr,
    input  logic        Imem_Gnt,
    input  logic        Imem_Rvalid,
    input  logic [31:0] Imem_Rdata,
    output logic [31:0] IF_IrOut,
    output logic [31:2] IF_PcAddOne,
    output logic        IF_Valid
);

    logic [1:0]  state;
    logic [31:2] pc;
    logic [31:2] pc_add_one;
    logic [31:0] ir_buf;
    // Set when the outstanding response belongs to a squashed (redirected-away) fetch
    logic        kill;

    // 30-bit add wraps modulo 2^30 naturally
    assign pc_add_one = pc + 30'd1;

    assign Imem_Req    = (state == ST_REQ);
    assign Imem_Addr   = pc;
    assign IF_Valid    = (state == ST_HOLD);
    assign IF_IrOut    = (state == ST_HOLD) ? ir_buf : NOP_INSTR;
    assign IF_PcAddOne = pc_add_one;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC[31:2];
            ir_buf <= NOP_INSTR;
            kill   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ID_Redirect) pc <= ID_Target;
                    state <= ST_REQ;
                end

                ST_REQ: begin
                    if (ID_Redirect) begin
                        pc <= ID_Target;
                        // Request for the old PC was accepted: its response must be dropped
                        if (Imem_Gnt) begin
                            state <= ST_WAIT;
                            kill  <= 1'b1;
                        end
                    end else if (Imem_Gnt) begin
                        state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (ID_Redirect) begin
                        pc <= ID_Target;
                        if (Imem_Rvalid) begin
                            state <= ST_REQ;
                            kill  <= 1'b0;
                        end else begin
                            kill  <= 1'b1;
                        end
                    end else if (Imem_Rvalid) begin
                        if (kill) begin
                            state <= ST_REQ;
                            kill  <= 1'b0;
                        end else begin
                            ir_buf <= Imem_Rdata;
                            state  <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (ID_Redirect) begin
                        pc    <= ID_Target;
                        state <= ST_REQ;
                    end else if (!ID_IFFlush || IF_ID_WR) begin
                        // A flushed instruction still counts as fetched, so PC advances
                        pc    <= pc_add_one;
                        state <= ST_REQ;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        IF_ID_WR = 1'b0;
    logic        ID_IFFlush = 1'b1;
    logic        ID_Redirect = 1'b0;
    logic [31:2] ID_Target = '0;
    logic        Imem_Gnt = 1'b0;
    logic        Imem_Rvalid = 1'b0;
    logic [31:0] Imem_Rdata = '0;

    logic        req1, req2, vld1, vld2;
    logic [31:2] addr1, addr2, pc1_1, pc1_2;
    logic [31:0] ir1, ir2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst(rst), .IF_ID_WR(IF_ID_WR), .ID_IFFlush(ID_IFFlush),
        .ID_Redirect(ID_Redirect), .ID_Target(ID_Target),
        .Imem_Req(req1), .Imem_Addr(addr1), .Imem_Gnt(Imem_Gnt),
        .Imem_Rvalid(Imem_Rvalid), .Imem_Rdata(Imem_Rdata),
        .IF_IrOut(ir1), .IF_PcAddOne(pc1_1), .IF_Valid(vld1)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .IF_ID_WR(IF_ID_WR), .ID_IFFlush(ID_IFFlush),
        .ID_Redirect(ID_Redirect), .ID_Target(ID_Target),
        .Imem_Req(req2), .Imem_Addr(addr2), .Imem_Gnt(Imem_Gnt),
        .Imem_Rvalid(Imem_Rvalid), .Imem_Rdata(Imem_Rdata),
        .IF_IrOut(ir2), .IF_PcAddOne(pc1_2), .IF_Valid(vld2)
    );

    typedef struct {
        logic        rst;
        logic        wr;
        logic        fl_n;
        logic        rd;
        logic [29:0] tgt;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [29:0] e_addr;
        logic        e_vld;
        logic [31:0] e_ir;
        logic [29:0] e_pc1;
    } vec_t;

    vec_t vecs[29];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic wr, input logic fl_n, input logic rd,
                         input logic [29:0] tgt, input logic gnt, input logic rv,
                         input logic [31:0] rdata);
        rst = r; IF_ID_WR = wr; ID_IFFlush = fl_n; ID_Redirect = rd;
        ID_Target = tgt; Imem_Gnt = gnt; Imem_Rvalid = rv; Imem_Rdata = rdata;
    endtask

    function automatic vec_t mk(input logic r, input logic wr, input logic fl_n, input logic rd,
                                input logic [29:0] tgt, input logic gnt, input logic rv,
                                input logic [31:0] rdata, input logic e_req,
                                input logic [29:0] e_addr, input logic e_vld,
                                input logic [31:0] e_ir, input logic [29:0] e_pc1);
        vec_t v;
        v.rst = r; v.wr = wr; v.fl_n = fl_n; v.rd = rd; v.tgt = tgt; v.gnt = gnt;
        v.rv = rv; v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
        v.e_ir = e_ir; v.e_pc1 = e_pc1;
        return v;
    endfunction

    initial begin
        // Inputs are applied at the falling edge; outputs checked 1ns later reflect
        // the state left by the previous rising edge.
        //             rst wr fl rd tgt       gnt rv rdata          req addr     vld ir             pc+1
        vecs[0]  = mk(1, 0, 1, 0, 30'h0,    0, 0, 32'h0,         0, 30'h0C00, 0, 32'h0,         30'h0C01); // reset
        vecs[1]  = mk(0, 0, 1, 0, 30'h0,    0, 0, 32'h0,         0, 30'h0C00, 0, 32'h0,         30'h0C01); // IDLE
        vecs[2]  = mk(0, 0, 1, 0, 30'h0,    1, 0, 32'h0,         1, 30'h0C00, 0, 32'h0,         30'h0C01); // REQ + gnt
        vecs[3]  = mk(0, 0, 1, 0, 30'h0,    0, 1, 32'h2408_0005, 0, 30'h0C00, 0, 32'h0,         30'h0C01); // WAIT + rvalid
        vecs[4]  = mk(0, 0, 1, 0, 30'h0,    0, 0, 32'h0,         0, 30'h0C00, 1, 32'h2408_0005, 30'h0C01); // HOLD stall
        vecs[5]  = mk(0, 0, 1, 0, 30'h0,    1, 1, 32'h1111_1111, 0, 30'h0C00, 1, 32'h2408_0005, 30'h0C01); // stray gnt/rvalid
        vecs[6]  = mk(0, 0, 1, 0, 30'h0,    0, 0, 32'h0,         0, 30'h0C00, 1, 32'h2408_0005, 30'h0C01);
        vecs[7]  = mk(0, 0, 1, 0, 30'h0,    0, 0, 32'h0,         0, 30'h0C00, 1, 32'h2408_0005, 30'h0C01);
        vecs[8]  = mk(0, 1, 1, 0, 30'h0,    0, 0, 32'h0,         0, 30'h0C00, 1, 32'h2408_0005, 30'h0C01); // consume
        vecs[9]  = mk(0, 0, 1, 0, 30'h0,    1, 0, 32'h0,         1, 30'h0C01, 0, 32'h0,         30'h0C02);
        vecs[10] = mk(0, 0, 1, 1, 30'h0D00, 0, 0, 32'h0,         0, 30'h0C01, 0, 32'h0,         30'h0C02); // redirect in WAIT
        vecs[11] = mk(0, 0, 1, 0, 30'h0,    0, 1, 32'hDEAD_BEEF, 0, 30'h0D00, 0, 32'h0,         30'h0D01); // late data dropped
        vecs[12] = mk(0, 0, 1, 0, 30'h0,    0, 0, 32'h0,         1, 30'h0D00, 0, 32'h0,         30'h0D01); // REQ, no gnt
        vecs[13] = mk(0, 0, 1, 0, 30'h0,    1, 0, 32'h0,         1, 30'h0D00, 0, 32'h0,         30'h0D01);
        vecs[14] = mk(0, 0, 1, 0, 30'h0,    0, 1, 32'h0000_1234, 0, 30'h0D00, 0, 32'h0,         30'h0D01);
        vecs[15] = mk(0, 0, 0, 0, 30'h0,    0, 0, 32'h0,         0, 30'h0D00, 1, 32'h0000_1234, 30'h0D01); // flush in HOLD
        vecs[16] = mk(0, 0, 1, 0, 30'h0,    1, 0, 32'h0,         1, 30'h0D01, 0, 32'h0,         30'h0D02);
        vecs[17] = mk(0, 0, 1, 0, 30'h0,    0, 1, 32'hAAAA_5555, 0, 30'h0D01, 0, 32'h0,         30'h0D02);
        vecs[18] = mk(0, 1, 1, 0, 30'h0,    0, 0, 32'h0,         0, 30'h0D01, 1, 32'hAAAA_5555, 30'h0D02);
        vecs[19] = mk(0, 0, 1, 1, 30'h0C02, 0, 0, 32'h0,         1, 30'h0D02, 0, 32'h0,         30'h0D03); // redirect in REQ
        vecs[20] = mk(0, 0, 1, 1, 30'h0E00, 1, 0, 32'h0,         1, 30'h0C02, 0, 32'h0,         30'h0C03); // redirect + gnt
        vecs[21] = mk(0, 0, 1, 0, 30'h0,    0, 1, 32'hBAD0_0C02, 0, 30'h0E00, 0, 32'h0,         30'h0E01); // stale response
        vecs[22] = mk(0, 0, 1, 0, 30'h0,    1, 0, 32'h0,         1, 30'h0E00, 0, 32'h0,         30'h0E01);
        vecs[23] = mk(0, 0, 1, 0, 30'h0,    0, 1, 32'h0E00_0001, 0, 30'h0E00, 0, 32'h0,         30'h0E01);
        vecs[24] = mk(0, 1, 0, 1, 30'h0F00, 0, 0, 32'h0,         0, 30'h0E00, 1, 32'h0E00_0001, 30'h0E01); // redirect wins
        vecs[25] = mk(0, 0, 0, 0, 30'h0,    0, 0, 32'h0,         1, 30'h0F00, 0, 32'h0,         30'h0F01); // flush in REQ
        vecs[26] = mk(0, 0, 0, 0, 30'h0,    1, 0, 32'h0,         1, 30'h0F00, 0, 32'h0,         30'h0F01);
        vecs[27] = mk(0, 0, 0, 0, 30'h0,    0, 1, 32'h0000_0005, 0, 30'h0F00, 0, 32'h0,         30'h0F01); // flush in WAIT
        vecs[28] = mk(0, 0, 1, 0, 30'h0,    0, 0, 32'h0,         0, 30'h0F00, 1, 32'h0000_0005, 30'h0F01);

        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].wr, vecs[i].fl_n, vecs[i].rd, vecs[i].tgt,
                  vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
            #1;
            chk($sformatf("v%0d req", i),   {31'd0, req1},  {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d addr", i),  {2'd0, addr1},  {2'd0, vecs[i].e_addr});
            chk($sformatf("v%0d valid", i), {31'd0, vld1},  {31'd0, vecs[i].e_vld});
            chk($sformatf("v%0d ir", i),    ir1,            vecs[i].e_ir);
            chk($sformatf("v%0d pc1", i),   {2'd0, pc1_1},  {2'd0, vecs[i].e_pc1});
        end

        // Reset while a response is outstanding: the late response must be ignored.
        @(negedge clk); drive(0, 1, 1, 0, 30'h0, 0, 0, 32'h0);  // HOLD -> REQ
        @(negedge clk); drive(0, 0, 1, 0, 30'h0, 1, 0, 32'h0);  // REQ + gnt -> WAIT
        @(negedge clk); drive(1, 0, 1, 0, 30'h0, 0, 0, 32'h0);  // async reset mid-WAIT
        #1;
        chk("rst_mid req",   {31'd0, req1}, 32'd0);
        chk("rst_mid addr",  {2'd0, addr1}, 32'h0000_0C00);
        chk("rst_mid valid", {31'd0, vld1}, 32'd0);
        // Wrap instance after reset: word 0x3FFF_FFFF, PC+1 wraps to 0
        chk("wrap rst addr", {2'd0, addr2}, 32'h3FFF_FFFF);
        chk("wrap rst pc1",  {2'd0, pc1_2}, 32'd0);
        @(negedge clk); drive(0, 0, 1, 0, 30'h0, 0, 1, 32'hDEAD_BEEF); // response after reset, in IDLE
        #1;
        chk("rst_idle req", {31'd0, req1}, 32'd0);
        @(negedge clk); drive(0, 0, 1, 0, 30'h0, 1, 0, 32'h0);
        #1;
        chk("rst_req req",   {31'd0, req1}, 32'd1);
        chk("rst_req valid", {31'd0, vld1}, 32'd0);
        chk("rst_req ir",    ir1,           32'd0);
        @(negedge clk); drive(0, 0, 1, 0, 30'h0, 0, 1, 32'h0000_0007);
        @(negedge clk); drive(0, 1, 1, 0, 30'h0, 0, 0, 32'h0);
        #1;
        chk("wrap hold valid", {31'd0, vld2}, 32'd1);
        chk("wrap hold ir",    ir2,           32'h0000_0007);
        chk("wrap hold addr",  {2'd0, addr2}, 32'h3FFF_FFFF);
        chk("wrap hold pc1",   {2'd0, pc1_2}, 32'd0);
        chk("main hold ir",    ir1,           32'h0000_0007);
        @(negedge clk); drive(0, 0, 1, 0, 30'h0, 0, 0, 32'h0);
        #1;
        chk("wrap next req",  {31'd0, req2}, 32'd1);
        chk("wrap next addr", {2'd0, addr2}, 32'd0);
        chk("wrap next pc1",  {2'd0, pc1_2}, 32'd1);
        chk("main next addr", {2'd0, addr1}, 32'h0000_0C01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
